y_signature_compactor: RTL and testbench

// Downstream response stage for the generated `top` datapath. It consumes the wide
// y vector one sample per accepted handshake and folds each sample into a SIG_W

---
 rtl/y_signature_compactor.sv | 130 +++++++++++++
 tb/tb_y_signature_compactor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/y_signature_compactor.sv
// Response compactor: folds each accepted wide sample into a SIG_W MISR over a
// fixed window of samples, then holds the signature until the consumer acks it.
module y_signature_compactor #(
  parameter int               DATA_W = 769,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF,
  parameter int               WINDOW = 256,
  parameter int               CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sig_valid,
  input  logic              sig_ack,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count,
  output logic              busy
);

  localparam int NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               load_s;
  logic               accept_s;
  logic               last_s;
  logic               ready_r;
  logic               done_r;
  logic [SIG_W-1:0]   sig_r;
  logic [CNT_W-1:0]   count_r;

  // XOR of all SIG_W-wide chunks of the zero-padded sample, chunk 0 at the LSB.
  function automatic logic [SIG_W-1:0] fold(input logic [DATA_W-1:0] d);
    logic [NCHUNK*SIG_W-1:0] padded;
    logic [SIG_W-1:0]        acc;
    padded             = '0;
    padded[DATA_W-1:0] = d;
    acc                = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      acc = acc ^ padded[k*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] f);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ f;
  endfunction

  assign accept_s = in_valid && ready_r;
  assign last_s   = accept_s && (count_r == CNT_W'(WINDOW - 1));

  // Next-state decode; load_s marks every entry into RUN.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (sig_ack && start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else if (sig_ack) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, registered status flags, MISR and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      sig_r   <= SEED;
      count_r <= '0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
      if (load_s) begin
        sig_r   <= SEED;
        count_r <= '0;
      end else if (accept_s) begin
        sig_r   <= misr_step(sig_r, fold(in_data));
        count_r <= count_r + CNT_W'(1);
      end else begin
        sig_r   <= sig_r;
        count_r <= count_r;
      end
    end
  end

  assign in_ready     = ready_r;
  assign busy         = ready_r;
  assign sig_valid    = done_r;
  assign signature    = sig_r;
  assign sample_count = count_r;

endmodule

// File: tb/tb_y_signature_compactor.sv
// Bench for y_signature_compactor: directed scenarios plus random windows checked
// against an arithmetic MISR model.
module tb_y_signature_compactor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, sig_ack;
  logic [15:0] in_data;
  logic        in_ready, sig_valid, busy;
  logic [7:0]  signature;
  logic [1:0]  sample_count;

  logic        start1, in_valid1, sig_ack1;
  logic [15:0] in_data1;
  logic        in_ready1, sig_valid1, busy1;
  logic [7:0]  signature1;
  logic [0:0]  sample_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y_signature_compactor #(.DATA_W(16), .SIG_W(8), .POLY(8'h07), .SEED(8'h00),
                          .WINDOW(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sig_valid(sig_valid), .sig_ack(sig_ack),
    .signature(signature), .sample_count(sample_count), .busy(busy));

  y_signature_compactor #(.DATA_W(16), .SIG_W(8), .POLY(8'h07), .SEED(8'h80),
                          .WINDOW(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .sig_valid(sig_valid1), .sig_ack(sig_ack1),
    .signature(signature1), .sample_count(sample_count1), .busy(busy1));

  // Reference: signature as a polynomial over GF(2), multiplied by x modulo POLY.
  function automatic int m_fold(input int d);
    int acc = 0;
    for (int k = 0; k < 2; k++) acc = acc ^ ((d / (1 << (8 * k))) % 256);
    return acc;
  endfunction

  function automatic int m_step(input int s, input int f, input int poly);
    int v = s * 2;
    if (v >= 256) v = (v - 256) ^ poly;
    return v ^ f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_window(input logic [15:0] d0, input logic [15:0] d1);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = d0; tick();
    in_data = d1; tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; tick();
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    checks++;
    if (signature !== 8'h00 || sample_count !== 2'd0 || in_ready !== 1'b0 ||
        sig_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async sig=%h cnt=%0d rdy=%b sv=%b busy=%b want 00/0/0/0/0",
               signature, sample_count, in_ready, sig_valid, busy);
    end
    tick(); rst_n = 1'b1; tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b busy=%b want 0/0", in_ready, busy);
    end
  endtask

  task automatic test_window();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || sample_count !== 2'd0) begin
      errors++;
      $display("FAIL start_run rdy=%b busy=%b cnt=%0d want 1/1/0", in_ready, busy, sample_count);
    end
    in_valid = 1'b1; in_data = 16'h0001; tick();
    checks++;
    if (signature !== 8'h01 || sample_count !== 2'd1) begin
      errors++;
      $display("FAIL window_first sig=%h cnt=%0d want 01/1", signature, sample_count);
    end
    in_data = 16'h0100; tick();
    checks++;
    if (signature !== 8'h03 || sig_valid !== 1'b1 || in_ready !== 1'b0 || sample_count !== 2'd2) begin
      errors++;
      $display("FAIL window_done sig=%h sv=%b rdy=%b cnt=%0d want 03/1/0/2",
               signature, sig_valid, in_ready, sample_count);
    end
  endtask

  task automatic test_done_hold();
    in_valid = 1'b1; in_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (signature !== 8'h03 || sig_valid !== 1'b1 || sample_count !== 2'd2) begin
        errors++;
        $display("FAIL done_hold[%0d] sig=%h sv=%b cnt=%0d want 03/1/2",
                 i, signature, sig_valid, sample_count);
      end
    end
    in_valid = 1'b0; sig_ack = 1'b1; tick(); sig_ack = 1'b0;
    checks++;
    if (sig_valid !== 1'b0 || busy !== 1'b0 || signature !== 8'h03) begin
      errors++;
      $display("FAIL ack_idle sv=%b busy=%b sig=%h want 0/0/03", sig_valid, busy, signature);
    end
  endtask

  task automatic test_seed_window1();
    start1 = 1'b1; tick(); start1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'h0000; tick(); in_valid1 = 1'b0;
    checks++;
    if (signature1 !== 8'h07 || sig_valid1 !== 1'b1 || sample_count1 !== 1'b1 || in_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL seed80_w1 sig=%h sv=%b cnt=%0d rdy=%b want 07/1/1/0",
               signature1, sig_valid1, sample_count1, in_ready1);
    end
    sig_ack1 = 1'b1; tick(); sig_ack1 = 1'b0;
  endtask

  task automatic test_ack_restart();
    fill_window(16'h0001, 16'h0100);
    sig_ack = 1'b1; start = 1'b1; tick(); sig_ack = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sig_valid !== 1'b0 || signature !== 8'h00 || sample_count !== 2'd0) begin
      errors++;
      $display("FAIL ack_restart busy=%b sv=%b sig=%h cnt=%0d want 1/0/00/0",
               busy, sig_valid, signature, sample_count);
    end
  endtask

  task automatic test_start_ignored();
    in_valid = 1'b1; in_data = 16'h0001; tick();
    in_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sample_count !== 2'd1 || signature !== 8'h01) begin
      errors++;
      $display("FAIL start_in_run busy=%b cnt=%0d sig=%h want 1/1/01", busy, sample_count, signature);
    end
    in_valid = 1'b1; in_data = 16'h0100; tick(); in_valid = 1'b0;
    checks++;
    if (sig_valid !== 1'b1 || signature !== 8'h03 || sample_count !== 2'd2) begin
      errors++;
      $display("FAIL start_in_run_end sv=%b sig=%h cnt=%0d want 1/03/2", sig_valid, signature, sample_count);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (sig_valid !== 1'b1 || signature !== 8'h03) begin
      errors++;
      $display("FAIL start_in_done sv=%b sig=%h want 1/03", sig_valid, signature);
    end
    sig_ack = 1'b1; tick(); sig_ack = 1'b0;
  endtask

  task automatic test_random();
    int m_sig, m_cnt, cyc;
    bit v;
    logic [15:0] d;
    for (int w = 0; w < 12; w++) begin
      start = 1'b1; tick(); start = 1'b0;
      m_sig = 0; m_cnt = 0; cyc = 0;
      while (m_cnt < 2 && cyc < 200) begin
        v = 1'($urandom_range(0, 1));
        d = 16'($urandom);
        in_valid = v;
        in_data  = v ? d : 16'hxxxx;
        tick();
        cyc++;
        if (v) begin
          m_sig = m_step(m_sig, m_fold(int'(d)), 8'h07);
          m_cnt++;
        end
        checks++;
        if (signature !== 8'(m_sig) || sample_count !== 2'(m_cnt) ||
            sig_valid !== (m_cnt == 2) || in_ready !== (m_cnt < 2)) begin
          errors++;
          $display("FAIL random[%0d] sig=%h cnt=%0d sv=%b rdy=%b want %h/%0d/%b/%b",
                   w, signature, sample_count, sig_valid, in_ready,
                   8'(m_sig), m_cnt, (m_cnt == 2), (m_cnt < 2));
        end
      end
      in_valid = 1'b0;
      if (m_cnt < 2) begin
        checks++; errors++;
        $display("FAIL random_timeout[%0d] cnt=%0d want 2", w, m_cnt);
      end
      sig_ack = 1'b1; tick(); sig_ack = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = 16'h0000; sig_ack = 1'b0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 16'h0000; sig_ack1 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_window();
    test_done_hold();
    test_seed_window1();
    test_ack_restart();
    test_start_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
